// File: rtl/vlc_ac_sequencer.sv
// Turns one block's scan-order AC coefficients into run/level exp-Golomb codewords with adaptive k.
// Latency: run codeword issued on the accept edge, level one cycle later, code_valid GC_LAT after issue.
// Backpressure: coef_ready drops in LEVEL and DRAIN; no output backpressure, one codeword per cycle out.
module vlc_ac_sequencer #(
    parameter int COEF_W = 16,
    parameter int GC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COEF_W-1:0] coef,
    input  logic              coef_valid,
    input  logic              coef_last,
    output logic              coef_ready,
    output logic [31:0]       gc_val,
    output logic [2:0]        gc_k,
    output logic [1:0]        gc_is_add_setbit,
    output logic              gc_is_ac_level,
    output logic              gc_is_ac_minus_n,
    input  logic [31:0]       gc_sum,
    input  logic [31:0]       gc_len,
    output logic              code_valid,
    output logic [31:0]       code_bits,
    output logic [31:0]       code_len,
    output logic              code_is_level,
    output logic              blk_done
);

    typedef enum logic [1:0] {SCAN, LEVEL, DRAIN} state_t;

    localparam logic [6:0]        RUN_INIT   = 7'd4;
    localparam logic [6:0]        RUN_MAX    = 7'd127;
    localparam logic [COEF_W-1:0] ONE        = COEF_W'(1);
    localparam logic [COEF_W-1:0] LEVEL_INIT = COEF_W'(2);

    state_t            state, state_nxt;
    logic [6:0]        run_cnt, prev_run;
    logic [COEF_W-1:0] mag, prev_level, coef_mag;
    logic              neg, last;
    logic [2:0]        run_k, level_k;
    logic              accept, coef_zero, issue_run, issue_lvl, push_done, drain_exit;
    logic [GC_LAT-1:0] tag_vld, tag_lvl, tag_done;

    assign coef_ready = (state == SCAN) && !reset;
    assign accept     = coef_valid && coef_ready;
    assign coef_zero  = (coef == '0);
    // |coef|-1 without a wider intermediate: for negatives ~x equals -x-1
    assign coef_mag   = coef[COEF_W-1] ? ~coef : coef - ONE;
    // The done marker rides the tag pipeline so blk_done trails the block's last codeword
    assign drain_exit = (state == DRAIN) && tag_done[GC_LAT-1];

    assign run_k   = (prev_run <= 7'd1) ? 3'd0 : (prev_run <= 7'd3) ? 3'd1 : 3'd2;
    assign level_k = (prev_level == ONE) ? 3'd0 : (prev_level <= COEF_W'(3)) ? 3'd1 : 3'd2;

    assign gc_is_add_setbit = 2'b00;
    assign code_valid       = tag_vld[GC_LAT-1];
    assign code_is_level    = tag_lvl[GC_LAT-1];
    assign code_bits        = gc_sum;
    assign code_len         = gc_len;

    always_ff @(posedge clk) begin
        if (reset) state <= SCAN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue_run = 1'b0;
        issue_lvl = 1'b0;
        push_done = 1'b0;
        case (state)
            SCAN: begin
                if (accept) begin
                    if (!coef_zero) begin
                        issue_run = 1'b1;
                        state_nxt = LEVEL;
                    end else if (coef_last) begin
                        push_done = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            LEVEL: begin
                issue_lvl = 1'b1;
                push_done = last;
                state_nxt = last ? DRAIN : SCAN;
            end
            DRAIN: begin
                if (tag_done[GC_LAT-1]) state_nxt = SCAN;
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt          <= '0;
            prev_run         <= RUN_INIT;
            prev_level       <= LEVEL_INIT;
            mag              <= '0;
            neg              <= 1'b0;
            last             <= 1'b0;
            gc_val           <= '0;
            gc_k             <= '0;
            gc_is_ac_level   <= 1'b0;
            gc_is_ac_minus_n <= 1'b0;
            tag_vld          <= '0;
            tag_lvl          <= '0;
            tag_done         <= '0;
            blk_done         <= 1'b0;
        end else begin
            gc_val           <= '0;
            gc_k             <= '0;
            gc_is_ac_level   <= 1'b0;
            gc_is_ac_minus_n <= 1'b0;
            if (issue_run) begin
                gc_val   <= 32'(run_cnt);
                gc_k     <= run_k;
                mag      <= coef_mag;
                neg      <= coef[COEF_W-1];
                last     <= coef_last;
                run_cnt  <= '0;
                prev_run <= run_cnt;
            end else if (accept && coef_zero && run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + 7'd1;
            end
            if (issue_lvl) begin
                gc_val           <= 32'(mag);
                gc_k             <= level_k;
                gc_is_ac_level   <= 1'b1;
                gc_is_ac_minus_n <= neg;
                prev_level       <= mag + ONE;
            end
            if (drain_exit) begin
                prev_run   <= RUN_INIT;
                prev_level <= LEVEL_INIT;
                run_cnt    <= '0;
            end
            tag_vld[0]  <= issue_run | issue_lvl;
            tag_lvl[0]  <= issue_lvl;
            tag_done[0] <= push_done;
            for (int i = 1; i < GC_LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_lvl[i]  <= tag_lvl[i-1];
                tag_done[i] <= tag_done[i-1];
            end
            blk_done <= drain_exit;
        end
    end

endmodule

// File: tb/tb_vlc_ac_sequencer.sv
// Bench for vlc_ac_sequencer: directed blocks, a codeword-level reference model and a per-cycle checker.
module tb_vlc_ac_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] coef;
    logic        coef_valid, coef_last, coef_ready;
    logic [31:0] gc_val;
    logic [2:0]  gc_k;
    logic [1:0]  gc_is_add_setbit;
    logic        gc_is_ac_level, gc_is_ac_minus_n;
    logic [31:0] gc_sum = '0, gc_len = '0;
    logic        code_valid, code_is_level, blk_done;
    logic [31:0] code_bits, code_len;

    always #5 clk = ~clk;

    vlc_ac_sequencer #(.COEF_W(16), .GC_LAT(2)) dut (
        .clk(clk), .reset(reset), .coef(coef), .coef_valid(coef_valid), .coef_last(coef_last),
        .coef_ready(coef_ready), .gc_val(gc_val), .gc_k(gc_k), .gc_is_add_setbit(gc_is_add_setbit),
        .gc_is_ac_level(gc_is_ac_level), .gc_is_ac_minus_n(gc_is_ac_minus_n),
        .gc_sum(gc_sum), .gc_len(gc_len), .code_valid(code_valid), .code_bits(code_bits),
        .code_len(code_len), .code_is_level(code_is_level), .blk_done(blk_done)
    );

    // Coder stand-in: output word tags its inputs so each codeword's value/k/sign can be read back
    always @(posedge clk) begin
        gc_sum <= {gc_is_ac_level, gc_is_ac_minus_n, 11'b0, gc_k, gc_val[15:0]};
        gc_len <= {gc_is_ac_level, 28'b0, gc_k};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int          cyc;
        logic        lvl;
        logic [31:0] bits;
        logic [31:0] len;
    } cw_t;

    cw_t         exp_q[$];
    int          done_q[$];
    logic [31:0] log_q[$];
    cw_t         ce;
    int          ready_from, m_run, m_prun, m_plev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int kof(input int v);
        if (v <= 1) return 0;
        if (v <= 3) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] enc(input logic lvl, input logic mn, input int k, input int val);
        return {lvl, mn, 11'b0, k[2:0], val[15:0]};
    endfunction

    function automatic logic [31:0] lenf(input logic lvl, input int k);
        return {lvl, 28'b0, k[2:0]};
    endfunction

    task automatic model_init();
        exp_q.delete();
        done_q.delete();
        m_run = 0; m_prun = 4; m_plev = 2;
        ready_from = 0;
    endtask

    // Codeword-level reference: what the coder must see, and when, for one accepted coefficient
    task automatic model_step(input int c, input bit last, input int ac);
        int mag, kr, kl;
        if (c == 0) begin
            if (m_run < 127) m_run++;
        end else begin
            mag = (c < 0 ? -c : c) - 1;
            kr  = kof(m_prun);
            kl  = kof(m_plev);
            exp_q.push_back('{ac + 2, 1'b0, enc(1'b0, 1'b0, kr, m_run), lenf(1'b0, kr)});
            exp_q.push_back('{ac + 3, 1'b1, enc(1'b1, c < 0, kl, mag), lenf(1'b1, kl)});
            m_prun = m_run; m_run = 0; m_plev = mag + 1;
            ready_from = ac + 2;
        end
        if (last) begin
            ready_from = ac + ((c == 0) ? 3 : 4);
            done_q.push_back(ready_from);
            m_run = 0; m_prun = 4; m_plev = 2;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (reset) begin
                chk("ready_in_reset", 32'(coef_ready), 32'd0);
            end else begin
                chk("coef_ready", 32'(coef_ready), 32'(cyc >= ready_from));
                chk("add_setbit", 32'(gc_is_add_setbit), 32'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    ce = exp_q.pop_front();
                    chk("code_valid", 32'(code_valid), 32'd1);
                    if (code_valid) begin
                        chk("code_is_level", 32'(code_is_level), 32'(ce.lvl));
                        chk("code_bits", code_bits, ce.bits);
                        chk("code_len", code_len, ce.len);
                    end
                end else begin
                    chk("code_valid_idle", 32'(code_valid), 32'd0);
                end
                if (code_valid) log_q.push_back(code_bits);
                if (done_q.size() > 0 && done_q[0] == cyc) begin
                    void'(done_q.pop_front());
                    chk("blk_done", 32'(blk_done), 32'd1);
                end else begin
                    chk("blk_done_idle", 32'(blk_done), 32'd0);
                end
            end
        end
    end

    // Entered and left 1 time unit after a rising edge; ac is the cycle of the accept
    task automatic send(input int c, input bit last, input int gap_max, output int ac);
        int g;
        bit done;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        coef_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
        coef = c[15:0]; coef_last = last; coef_valid = 1'b1;
        ac = -1; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (coef_ready) begin ac = cyc; done = 1'b1; end
            @(posedge clk); #1;
        end
        coef_valid = 1'b0; coef_last = 1'b0;
        if (done) model_step(c, last, ac);
        else chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic at_cyc(input int t);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cyc >= t) break;
        end
    endtask

    task automatic chk_cw(input int idx, input logic lvl, input logic mn, input int k, input int val);
        logic [31:0] act;
        act = (idx < log_q.size()) ? log_q[idx] : 32'hxxxxxxxx;
        chk($sformatf("cw%0d", idx), act, enc(lvl, mn, k, val));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    int ac, base, base2;
    int blk[63];

    initial begin
        reset = 1'b1; coef = '0; coef_valid = 1'b0; coef_last = 1'b0;
        model_init();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(coef_ready), 32'd0);
        chk("rst_code_valid", 32'(code_valid), 32'd0);
        chk("rst_blk_done", 32'(blk_done), 32'd0);
        chk("rst_gc_val", gc_val, 32'd0);
        chk("rst_gc_k", 32'(gc_k), 32'd0);
        chk("rst_gc_level", 32'(gc_is_ac_level), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(coef_ready), 32'd1);
        @(posedge clk); #1;

        // {0,0,3} with last on the 3
        send(0, 1'b0, 0, ac);
        send(0, 1'b0, 0, ac);
        base = log_q.size();
        send(3, 1'b1, 0, ac);
        @(negedge clk);
        chk("t1_run_val", gc_val, 32'd2);
        chk("t1_run_k", 32'(gc_k), 32'd2);
        chk("t1_run_lvl", 32'(gc_is_ac_level), 32'd0);
        chk("t1_ready_level", 32'(coef_ready), 32'd0);
        @(negedge clk);
        chk("t1_lvl_val", gc_val, 32'd2);
        chk("t1_lvl_k", 32'(gc_k), 32'd1);
        chk("t1_lvl_lvl", 32'(gc_is_ac_level), 32'd1);
        chk("t1_lvl_minus", 32'(gc_is_ac_minus_n), 32'd0);
        chk("t1_cv_run", 32'(code_valid), 32'd1);
        chk("t1_cv_run_kind", 32'(code_is_level), 32'd0);
        @(negedge clk);
        chk("t1_cv_lvl", 32'(code_valid), 32'd1);
        chk("t1_cv_lvl_kind", 32'(code_is_level), 32'd1);
        @(negedge clk);
        chk("t1_blk_done", 32'(blk_done), 32'd1);
        chk_cw(base, 1'b0, 1'b0, 2, 2);
        chk_cw(base + 1, 1'b1, 1'b0, 1, 2);
        @(posedge clk); #1;

        // {-1,5,1} with last on the 1
        base = log_q.size();
        send(-1, 1'b0, 0, ac);
        send(5, 1'b0, 0, ac);
        send(1, 1'b1, 0, ac);
        at_cyc(ac + 4);
        chk_cw(base,     1'b0, 1'b0, 2, 0);
        chk_cw(base + 1, 1'b1, 1'b1, 1, 0);
        chk_cw(base + 2, 1'b0, 1'b0, 0, 0);
        chk_cw(base + 3, 1'b1, 1'b0, 0, 4);
        chk_cw(base + 4, 1'b0, 1'b0, 0, 0);
        chk_cw(base + 5, 1'b1, 1'b0, 2, 0);
        @(posedge clk); #1;

        // 63 zeros: no codewords, blk_done three cycles after the final accept
        base = log_q.size();
        for (int i = 0; i < 63; i++) send(0, i == 62, 0, ac);
        @(negedge clk);
        chk("t3_done_early1", 32'(blk_done), 32'd0);
        @(negedge clk);
        chk("t3_done_early2", 32'(blk_done), 32'd0);
        @(negedge clk);
        chk("t3_blk_done", 32'(blk_done), 32'd1);
        chk("t3_no_codewords", 32'(log_q.size()), 32'(base));
        @(posedge clk); #1;

        // Same random block gap-free then with random valid gaps, back to back
        for (int i = 0; i < 63; i++)
            blk[i] = ($urandom_range(9, 0) < 7) ? 0 : int'($urandom_range(40, 0)) - 20;
        base = log_q.size();
        for (int i = 0; i < 63; i++) send(blk[i], i == 62, 0, ac);
        base2 = log_q.size();
        for (int i = 0; i < 63; i++) send(blk[i], i == 62, 3, ac);
        at_cyc(ac + 5);
        chk("t4_cw_count", 32'(log_q.size() - base2), 32'(base2 - base));
        for (int i = 0; i < base2 - base && base2 + i < log_q.size(); i++)
            chk($sformatf("t4_cw%0d", i), log_q[base2 + i], log_q[base + i]);
        @(posedge clk); #1;

        // Reset while in LEVEL
        send(0, 1'b0, 0, ac);
        send(7, 1'b0, 0, ac);
        reset = 1'b1;
        model_init();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_no_level", 32'(gc_is_ac_level), 32'd0);
        chk("t5_gc_val", gc_val, 32'd0);
        chk("t5_cv_flushed", 32'(code_valid), 32'd0);
        @(posedge clk); #1;
        base = log_q.size();
        send(0, 1'b0, 0, ac);
        send(2, 1'b1, 0, ac);
        at_cyc(ac + 4);
        chk_cw(base,     1'b0, 1'b0, 2, 1);
        chk_cw(base + 1, 1'b1, 1'b0, 1, 1);
        @(posedge clk); #1;

        // Most negative coefficient
        base = log_q.size();
        send(-32768, 1'b1, 0, ac);
        at_cyc(ac + 4);
        chk_cw(base,     1'b0, 1'b0, 2, 0);
        chk_cw(base + 1, 1'b1, 1'b1, 1, 32767);
        @(posedge clk); #1;

        // Run counter saturation
        base = log_q.size();
        for (int i = 0; i < 130; i++) send(0, 1'b0, 0, ac);
        send(1, 1'b1, 0, ac);
        at_cyc(ac + 6);
        chk_cw(base,     1'b0, 1'b0, 2, 127);
        chk_cw(base + 1, 1'b1, 1'b0, 1, 0);
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        chk("done_drained", 32'(done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/vlc_ac_sequencer.md
# vlc_ac_sequencer

Sequences one block's quantized AC coefficients, in scan order, through the shared exp-Golomb coder. Converts the coefficient stream into alternating run/level codewords, selects the adaptive Golomb parameter `k` for each codeword, and drives the coder's inputs. It then re-aligns the coder's 2-cycle-latency outputs with per-codeword tags for the bit packer. It sits between the quantizer/scan stage and the bitstream packer in the VLC path.

## Interface

**Parameters**
- `COEF_W`, default 16: signed coefficient width.
- `GC_LAT`, default 2: coder input-to-output latency in clocks.

**Ports**
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `coef` in COEF_W: signed quantized AC coefficient.
- `coef_valid` in 1: `coef` is valid.
- `coef_last` in 1: `coef` is the final AC coefficient of the block.
- `coef_ready` out 1: sequencer accepts `coef` this cycle.
- `gc_val` out 32: coder value input.
- `gc_k` out 3: coder `k`.
- `gc_is_add_setbit` out 2: coder add-setbit; always 0.
- `gc_is_ac_level` out 1: current codeword is a level.
- `gc_is_ac_minus_n` out 1: level sign (1 = negative).
- `gc_sum` in 32: coder codeword bits, valid `GC_LAT` clocks after issue.
- `gc_len` in 32: coder codeword length, same timing as `gc_sum`.
- `code_valid` out 1: `code_bits`/`code_len` are valid.
- `code_bits` out 32: pass-through of `gc_sum`.
- `code_len` out 32: pass-through of `gc_len`.
- `code_is_level` out 1: the codeword is a level (0 = run).
- `blk_done` out 1: one-cycle pulse after the block's last codeword has been presented.

## Operation

**States**
- `SCAN`, `LEVEL`, `DRAIN`. Reset state is `SCAN`.

**SCAN**
- `coef_ready` = 1.
- On accept of a zero coefficient: `run_cnt` += 1. The counter is 7 bits and saturates at 127.
- On accept of a nonzero coefficient: issue a run codeword with `gc_val`=`run_cnt`, `gc_k`=`run_k`, `gc_is_ac_level`=0.
  - Latch `mag` = |coef| − 1 (COEF_W bits, zero-extended to 32), `neg` = coef[MSB], and `last` = `coef_last`.
  - Clear `run_cnt`. Set `prev_run` to the run value just issued.
  - Go to `LEVEL`.
- On accept of a zero coefficient with `coef_last`=1: trailing zeros produce no codeword. Go to `DRAIN`.

**LEVEL**
- `coef_ready` = 0.
- Issue a level codeword with `gc_val`=`mag`, `gc_k`=`level_k`, `gc_is_ac_level`=1, `gc_is_ac_minus_n`=`neg`.
- Set `prev_level` = `mag` + 1.
- Go to `DRAIN` if `last` is set, else to `SCAN`.

**DRAIN**
- `coef_ready` = 0.
- Wait until the tag pipeline is empty, pulse `blk_done`, then reinitialize `prev_run`/`prev_level` and go to `SCAN`.

**k selection**
- Evaluated from registered history.
- `run_k`: 0 if `prev_run` ≤ 1; 1 if ≤ 3; otherwise 2.
- `level_k`: 0 if `prev_level` = 1; 1 if ≤ 3; otherwise 2.
- Block-start history: `prev_run` = 4, `prev_level` = 2, giving `run_k`=2 and `level_k`=1 for the first codewords.

**Coder inputs and idle cycles**
- Coder inputs are driven every cycle.
- In cycles with no issue, `gc_val`=0 and `gc_k`=0. These cycles produce coder output that is ignored.

**Tag pipeline**
- A `GC_LAT`-deep shift register of {issue, is_level}.
- `code_valid`/`code_is_level` are its output stage.
- `code_bits`/`code_len` are combinational pass-throughs of `gc_sum`/`gc_len`.

**Backpressure**
- There is no output backpressure; the packer must accept one codeword per cycle.

## Timing

**Reset values**
- `coef_ready`=0 during reset, 1 in the first cycle after reset.
- `code_valid`=0, `blk_done`=0, all `gc_*`=0, `run_cnt`=0.
- Tag pipeline cleared.

**Latency**
- Run issue occurs in the same cycle the nonzero coefficient is accepted (registered outputs, visible the following edge to the coder).
- Level issue follows exactly one cycle later.
- `code_valid` asserts `GC_LAT` cycles after each issue.

**Throughput**
- A nonzero coefficient costs 2 cycles; a zero coefficient costs 1 cycle.

**blk_done**
- Asserted exactly one cycle after the final `code_valid` of the block.
- For an all-zero block, asserted `GC_LAT`+1 cycles after the last accept.

**Boundary cases**
- Back-to-back blocks: `SCAN` resumes after `blk_done` with history reset. No codeword crosses a block boundary.
- `coef_valid` low in `SCAN`: no state change and no issue.
- Reset mid-block (including during `LEVEL` or `DRAIN`): all pending tags are discarded, no `blk_done` is generated, and the FSM returns to `SCAN` with initial history.
- `coef` = −2^(COEF_W−1): `mag` = 2^(COEF_W−1) − 1, `neg`=1. No overflow.
- `run_cnt` saturation is unreachable for legal 63-coefficient blocks but is required behaviour.

## Test plan

1. Block `{0,0,3,…}` with `coef_last` on the 3rd coefficient:
   - run issue `gc_val`=2, `k`=2, `ac_level`=0;
   - then level `gc_val`=2, `k`=1, `ac_level`=1, `minus`=0;
   - `code_valid` exactly 2 cycles after each issue;
   - `blk_done` 1 cycle after the second `code_valid`.
2. Coefficients `{−1, 5, 1}`, last on 1:
   - run/`k` sequence 0/2, 0/0, 0/0;
   - level/`k` sequence 0/1 (`minus`=1), 4/0, 0/2;
   - `coef_ready` low in every `LEVEL` cycle.
3. 63 zeros, last on the 63rd: no `code_valid` at any point; `blk_done` 3 cycles after the final accept.
4. `coef_valid` toggled randomly across a 63-coefficient block: the issued codeword sequence is identical to the gap-free run.
5. `reset` asserted in `LEVEL` mid-block: the level is not issued, `code_valid`=0 from the next cycle, and no `blk_done`. The next block starts with `run_k`=2.
6. `coef` = −32768, last: level `gc_val`=32767 with `minus`=1.
